multi_clk_div: RTL

- Parametrised, multi-channel successor to the single fixed-rate slow-clock generator.
- Derives NUM_CH independent square-wave clock enables and one-cycle tick strobes from the 100 MHz board clock.
- Each channel's half-period divisor is reprogrammable at runtime through a valid/ready config port; new divisors take effect glitch-free.
- Feeds display multiplexing, debouncers and slow FSMs, which use clk_out or the tick strobes.

---
 rtl/multi_clk_div_if.sv | 27 ++
 rtl/multi_clk_div.sv | 128 ++++++++++++
 2 files changed

// File: rtl/multi_clk_div_if.sv
// Configuration port of multi_clk_div: valid/ready write of a new
// half-period divisor into one channel.
interface multi_clk_div_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 27
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      output cfg_ready
   );
endinterface

// File: rtl/multi_clk_div.sv
// Multi-channel clock divider. Each channel produces a 50% duty square
// wave (clk_out) with half-period div cycles and a one-cycle tick at each
// toggle. Divisors are rewritten at runtime through the cfg port; a new
// divisor is parked as pending and only takes over at a terminal count
// (or at once when the channel is idle), so no output half-period is cut
// short.
//
// Optional build macro MULTI_CLK_DIV_SYNC_EN adds a sync_in input that
// restarts every enabled channel from phase 0 and applies pending
// divisors immediately.
module multi_clk_div #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 27,
   parameter int DEFAULT_DIV = 125000
) (
   input  logic              clk,
   input  logic              resetSW_n,
   input  logic [NUM_CH-1:0] ch_en,
`ifdef MULTI_CLK_DIV_SYNC_EN
   input  logic              sync_in,
`endif
   multi_clk_div_if.slave    cfg,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic              sync;
   logic              ready;
   logic              accept;
   logic [NUM_CH-1:0] pending;

`ifdef MULTI_CLK_DIV_SYNC_EN
   assign sync = sync_in;
`else
   assign sync = 1'b0;
`endif

   // Ready follows the pending flag of the addressed channel; channels that
   // do not exist always accept (and drop) the write. Blocked during sync.
   always_comb begin
      ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg.cfg_ch == CH_W'(i)) begin
            ready = ~pending[i];
         end
      end
      if (sync) begin
         ready = 1'b0;
      end
   end

   assign cfg.cfg_ready = ready;
   assign accept        = cfg.cfg_valid & ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] div_q;
      logic [CNT_W-1:0] pend_div_q;
      logic             pend_q;
      logic             clk_q;
      logic             tick_q;
      logic             running;
      logic             term;
      logic             acc;

      assign running = ch_en[g] & (div_q != '0);
      assign term    = running & (cnt_q == div_q - ONE);
      assign acc     = accept & (cfg.cfg_ch == CH_W'(g));

      assign pending[g] = pend_q;
      assign clk_out[g] = clk_q;
      assign tick[g]    = tick_q;

      // Channel counter, output toggle and divisor hand-over. A write
      // accepted on a terminal-count cycle sees pend_q=0 there, so it waits
      // for the following terminal count.
      always_ff @(posedge clk or negedge resetSW_n) begin
         if (!resetSW_n) begin
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
         end else if (sync && ch_en[g]) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            if (pend_q) begin
               div_q  <= pend_div_q;
               pend_q <= 1'b0;
            end
         end else begin
            if (acc) begin
               pend_q     <= 1'b1;
               pend_div_q <= cfg.cfg_div;
            end
            if (!running) begin
               cnt_q  <= '0;
               tick_q <= 1'b0;
               if (!ch_en[g]) begin
                  clk_q <= 1'b0;
               end
               if (pend_q) begin
                  div_q  <= pend_div_q;
                  pend_q <= 1'b0;
               end
            end else if (term) begin
               cnt_q  <= '0;
               clk_q  <= ~clk_q;
               tick_q <= 1'b1;
               if (pend_q) begin
                  div_q  <= pend_div_q;
                  pend_q <= 1'b0;
               end
            end else begin
               cnt_q  <= cnt_q + ONE;
               tick_q <= 1'b0;
            end
         end
      end
   end

endmodule
